// File: rtl/obstacle_field_if.sv
// Bus between the dodge-game obstacle manager and its player/sprite neighbours.
// The game logic owns the slave side; the player controller and sprite mux sit on the master side.
interface obstacle_field_if #(
   parameter int unsigned N_OBST  = 5,
   parameter int unsigned SCORE_W = 7
);
   logic                   tick;
   logic                   start;
   logic [9:0]             player_x;
   logic [9:0]             player_y;
   logic [N_OBST*10-1:0]   obj_x;
   logic [N_OBST*10-1:0]   obj_y;
   logic [N_OBST-1:0]      obj_active;
   logic [SCORE_W-1:0]     score;
   logic [SCORE_W-1:0]     max_score;
   logic                   playing;
   logic                   game_over;
   logic                   collision;

   modport master (
      output tick, start, player_x, player_y,
      input  obj_x, obj_y, obj_active, score, max_score, playing, game_over, collision
   );

   modport slave (
      input  tick, start, player_x, player_y,
      output obj_x, obj_y, obj_active, score, max_score, playing, game_over, collision
   );
endinterface

// File: rtl/obstacle_field.sv
// Obstacle manager for the dodge game: LFSR spawning, falling motion, level-based speed-up,
// player hit detection, score tracking and the IDLE/PLAY/OVER game FSM.
module obstacle_field #(
   parameter int unsigned N_OBST    = 5,
   parameter int unsigned OBJ_W     = 32,
   parameter int unsigned OBJ_H     = 32,
   parameter int unsigned PLAYER_W  = 32,
   parameter int unsigned PLAYER_H  = 32,
   parameter int unsigned SCREEN_W  = 640,
   parameter int unsigned SCREEN_H  = 480,
   parameter int unsigned SPAWN_GAP = 40,
   parameter int unsigned STEP_MIN  = 1,
   parameter int unsigned STEP_MAX  = 7,
   parameter int unsigned LEVEL_PTS = 10,
   parameter int unsigned SCORE_W   = 7,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic               CLOCK_50,
   input  logic               reset_n,
   obstacle_field_if.slave    bus
);

   localparam int unsigned POS_W  = 10;
   localparam int unsigned SUM_W  = 11;
   localparam int unsigned CNT_W  = $clog2(N_OBST + 1);
   localparam int unsigned TMR_W  = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
   localparam int unsigned STEP_W = $clog2(STEP_MAX + 2);
   localparam int unsigned LVL_W  = $clog2(LEVEL_PTS + N_OBST + 1);
   localparam int unsigned SCW    = SCORE_W + CNT_W;
   localparam int unsigned X_SPAN = SCREEN_W - OBJ_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic                    playing;
   logic                    game_over;
   logic                    collision;

   logic [15:0]             lfsr;
   logic [N_OBST*POS_W-1:0] pos_x;
   logic [N_OBST*POS_W-1:0] pos_y;
   logic [N_OBST-1:0]       active;
   logic [SCORE_W-1:0]      score;
   logic [SCORE_W-1:0]      best;
   logic [STEP_W-1:0]       step;
   logic [TMR_W-1:0]        timer;
   logic [LVL_W-1:0]        level;

   logic                    hit;
   logic                    enter_play;
   logic                    do_step;
   logic                    do_hit;

   logic [N_OBST*POS_W-1:0] x_next;
   logic [N_OBST*POS_W-1:0] y_next;
   logic [N_OBST-1:0]       active_next;
   logic [CNT_W-1:0]        exits;
   logic                    free_found;
   logic                    tmr_full;
   logic [TMR_W-1:0]        timer_next;
   logic [POS_W-1:0]        spawn_x;
   logic [SUM_W-1:0]        sum;
   logic [SCW-1:0]          score_sum;
   logic [SCORE_W-1:0]      score_next;
   logic [LVL_W-1:0]        level_sum;
   logic [LVL_W-1:0]        level_next;
   logic [STEP_W-1:0]       step_next;

   // Game state register; status flags follow the next state so they line up with it
   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         state     <= IDLE;
         playing   <= 1'b0;
         game_over <= 1'b0;
      end else begin
         state     <= state_next;
         playing   <= (state_next == PLAY);
         game_over <= (state_next == OVER);
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start) state_next = PLAY;
         PLAY:    if (hit)       state_next = OVER;
         OVER:    if (bus.start) state_next = PLAY;
         default:                state_next = IDLE;
      endcase
   end

   // Control strobes: a hit outranks a same-cycle tick
   always_comb begin
      enter_play = 1'b0;
      do_step    = 1'b0;
      do_hit     = 1'b0;
      case (state)
         IDLE, OVER: enter_play = bus.start;
         PLAY: begin
            do_hit  = hit;
            do_step = bus.tick && !hit;
         end
         default: ;
      endcase
   end

   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < N_OBST; i++) begin
         if (active[i] &&
             (SUM_W'(pos_x[POS_W*i +: POS_W]) < SUM_W'(bus.player_x) + SUM_W'(PLAYER_W)) &&
             (SUM_W'(bus.player_x) < SUM_W'(pos_x[POS_W*i +: POS_W]) + SUM_W'(OBJ_W)) &&
             (SUM_W'(pos_y[POS_W*i +: POS_W]) < SUM_W'(bus.player_y) + SUM_W'(PLAYER_H)) &&
             (SUM_W'(bus.player_y) < SUM_W'(pos_y[POS_W*i +: POS_W]) + SUM_W'(OBJ_H))) begin
            hit = 1'b1;
         end
      end
   end

   // Fold the 10-bit random value back into the visible spawn span
   always_comb begin
      if (lfsr[9:0] > POS_W'(X_SPAN)) spawn_x = lfsr[9:0] - POS_W'(X_SPAN);
      else                            spawn_x = lfsr[9:0];
   end

   // Per-tick motion, exit detection and spawn into the lowest slot that was already free
   always_comb begin
      x_next      = pos_x;
      y_next      = pos_y;
      active_next = active;
      exits       = '0;
      free_found  = 1'b0;
      sum         = '0;
      tmr_full    = (timer == TMR_W'(SPAWN_GAP - 1));
      for (int i = 0; i < N_OBST; i++) begin
         sum = SUM_W'(pos_y[POS_W*i +: POS_W]) + SUM_W'(step);
         if (active[i]) begin
            if (sum >= SUM_W'(SCREEN_H)) begin
               active_next[i]             = 1'b0;
               y_next[POS_W*i +: POS_W]   = '0;
               exits                      = exits + CNT_W'(1);
            end else begin
               y_next[POS_W*i +: POS_W]   = sum[POS_W-1:0];
            end
         end else if (!free_found) begin
            free_found = 1'b1;
            if (tmr_full) begin
               active_next[i]             = 1'b1;
               y_next[POS_W*i +: POS_W]   = '0;
               x_next[POS_W*i +: POS_W]   = spawn_x;
            end
         end
      end
   end

   always_comb begin
      if (!tmr_full)       timer_next = timer + TMR_W'(1);
      else if (free_found) timer_next = '0;
      else                 timer_next = timer;
   end

   // Saturating score; level counter carries into at most one step increment per tick
   always_comb begin
      score_sum = SCW'(score) + SCW'(exits);
      if (score_sum > SCW'({SCORE_W{1'b1}})) score_next = {SCORE_W{1'b1}};
      else                                    score_next = score_sum[SCORE_W-1:0];

      level_sum  = level + LVL_W'(exits);
      level_next = level_sum;
      step_next  = step;
      if (level_sum >= LVL_W'(LEVEL_PTS)) begin
         level_next = level_sum - LVL_W'(LEVEL_PTS);
         if (step < STEP_W'(STEP_MAX)) step_next = step + STEP_W'(1);
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         lfsr      <= LFSR_SEED;
         pos_x     <= '0;
         pos_y     <= '0;
         active    <= '0;
         score     <= '0;
         best      <= '0;
         step      <= STEP_W'(STEP_MIN);
         timer     <= '0;
         level     <= '0;
         collision <= 1'b0;
      end else begin
         lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         collision <= do_hit;
         if (enter_play) begin
            pos_x  <= '0;
            pos_y  <= '0;
            active <= '0;
            score  <= '0;
            step   <= STEP_W'(STEP_MIN);
            timer  <= '0;
            level  <= '0;
         end else if (do_hit) begin
            if (score > best) best <= score;
         end else if (do_step) begin
            pos_x  <= x_next;
            pos_y  <= y_next;
            active <= active_next;
            score  <= score_next;
            level  <= level_next;
            step   <= step_next;
            timer  <= timer_next;
         end
      end
   end

   assign bus.obj_x      = pos_x;
   assign bus.obj_y      = pos_y;
   assign bus.obj_active = active;
   assign bus.score      = score;
   assign bus.max_score  = best;
   assign bus.playing    = playing;
   assign bus.game_over  = game_over;
   assign bus.collision  = collision;

endmodule

// File: tb/tb_obstacle_field.sv
// Directed scoreboard bench for obstacle_field: three instances cover spawning, exits,
// level speed-up, step ceiling, score saturation, collision and restart.
module tb_obstacle_field;

   localparam logic [15:0] SEED = 16'hACE1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   obstacle_field_if #(.N_OBST(5), .SCORE_W(7)) ia ();
   obstacle_field_if #(.N_OBST(2), .SCORE_W(3)) ib ();
   obstacle_field_if #(.N_OBST(1), .SCORE_W(7)) ic ();

   obstacle_field #(.N_OBST(5), .SPAWN_GAP(4)) dut_a (
      .CLOCK_50 (clk),
      .reset_n  (rst_n),
      .bus      (ia)
   );

   obstacle_field #(.N_OBST(2), .SPAWN_GAP(1), .SCORE_W(3)) dut_b (
      .CLOCK_50 (clk),
      .reset_n  (rst_n),
      .bus      (ib)
   );

   obstacle_field #(.N_OBST(1), .SPAWN_GAP(1), .SCREEN_H(100), .LEVEL_PTS(1)) dut_c (
      .CLOCK_50 (clk),
      .reset_n  (rst_n),
      .bus      (ic)
   );

   // Reference LFSR; remembers its value at the most recent tick edge of dut_a / dut_c
   logic [15:0] lfsr_m;
   logic [15:0] last_a;
   logic [15:0] last_c;
   always @(posedge clk) begin
      if (!rst_n) lfsr_m <= SEED;
      else        lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
      if (ia.tick) last_a <= lfsr_m;
      if (ic.tick) last_c <= lfsr_m;
   end

   function automatic logic [9:0] fold(input logic [15:0] v);
      logic [9:0] r;
      r = v[9:0];
      if (r > 10'd608) r = r - 10'd608;
      return r;
   endfunction

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic expect_v(input string tag, input logic [63:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic observe(input logic [63:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val)
         else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic ticks(input int which, input int n);
      @(negedge clk);
      case (which)
         0:       ia.tick = 1'b1;
         1:       ib.tick = 1'b1;
         default: ic.tick = 1'b1;
      endcase
      repeat (n) @(negedge clk);
      ia.tick = 1'b0;
      ib.tick = 1'b0;
      ic.tick = 1'b0;
   endtask

   task automatic start_pulse(input int which);
      @(negedge clk);
      case (which)
         0:       ia.start = 1'b1;
         1:       ib.start = 1'b1;
         default: ic.start = 1'b1;
      endcase
      @(negedge clk);
      ia.start = 1'b0;
      ib.start = 1'b0;
      ic.start = 1'b0;
   endtask

   logic [9:0] xa0;
   logic [9:0] xc;

   initial begin
      rst_n = 1'b0;
      ia.tick = 1'b0; ia.start = 1'b0; ia.player_x = 10'd0; ia.player_y = 10'd440;
      ib.tick = 1'b0; ib.start = 1'b0; ib.player_x = 10'd0; ib.player_y = 10'd600;
      ic.tick = 1'b0; ic.start = 1'b0; ic.player_x = 10'd0; ic.player_y = 10'd600;

      // Reset state
      expect_v("rst_a_playing", 0);   expect_v("rst_a_game_over", 0);
      expect_v("rst_a_collision", 0); expect_v("rst_a_score", 0);
      expect_v("rst_a_max", 0);       expect_v("rst_a_active", 0);
      expect_v("rst_a_obj_x", 0);     expect_v("rst_a_obj_y", 0);
      expect_v("rst_b_playing", 0);   expect_v("rst_c_active", 0);
      repeat (2) @(negedge clk);
      observe(ia.playing);   observe(ia.game_over);
      observe(ia.collision); observe(ia.score);
      observe(ia.max_score); observe(ia.obj_active);
      observe(ia.obj_x);     observe(ia.obj_y);
      observe(ib.playing);   observe(ic.obj_active);

      // Start with a simultaneous tick: transition only, tick dropped
      expect_v("a_start_playing", 1);
      expect_v("a_start_active", 0);
      rst_n = 1'b1;
      ia.start = 1'b1;
      ia.tick  = 1'b1;
      @(negedge clk);
      observe(ia.playing);
      observe(ia.obj_active);
      ia.start = 1'b0;
      ia.tick  = 1'b0;

      // First spawn after SPAWN_GAP ticks
      expect_v("a_spawn1_active", 5'b00001);
      expect_v("a_spawn1_y0", 0);
      expect_v("a_spawn1_x_in_range", 1);
      ticks(0, 4);
      xa0 = fold(last_a);
      expect_v("a_spawn1_x0", xa0);
      observe(ia.obj_active);
      observe(ia.obj_y[9:0]);
      observe(ia.obj_x[9:0] <= 10'd608);
      observe(ia.obj_x[9:0]);

      expect_v("a_spawn2_active", 5'b00011);
      expect_v("a_spawn2_y0", 4);
      expect_v("a_spawn2_y1", 0);
      expect_v("a_spawn2_x0_held", xa0);
      ticks(0, 4);
      expect_v("a_spawn2_x1", fold(last_a));
      observe(ia.obj_active);
      observe(ia.obj_y[9:0]);
      observe(ia.obj_y[19:10]);
      observe(ia.obj_x[9:0]);
      observe(ia.obj_x[19:10]);

      // start while playing is ignored
      expect_v("a_start_in_play_active", 5'b00011);
      expect_v("a_start_in_play_y0", 4);
      expect_v("a_start_in_play_playing", 1);
      start_pulse(0);
      observe(ia.obj_active);
      observe(ia.obj_y[9:0]);
      observe(ia.playing);

      // Two-slot field: no extra spawn, exit scoring, respawn one tick later
      start_pulse(1);
      expect_v("b_full_active", 2'b11);
      expect_v("b_full_y0", 9);
      expect_v("b_full_y1", 8);
      ticks(1, 10);
      observe(ib.obj_active);
      observe(ib.obj_y[9:0]);
      observe(ib.obj_y[19:10]);

      expect_v("b_exit0_active", 2'b10);
      expect_v("b_exit0_score", 1);
      expect_v("b_exit0_y0", 0);
      expect_v("b_exit0_y1", 479);
      ticks(1, 471);
      observe(ib.obj_active);
      observe(ib.score);
      observe(ib.obj_y[9:0]);
      observe(ib.obj_y[19:10]);

      expect_v("b_respawn_active", 2'b01);
      expect_v("b_respawn_score", 2);
      expect_v("b_respawn_y0", 0);
      expect_v("b_respawn_y1", 0);
      ticks(1, 1);
      observe(ib.obj_active);
      observe(ib.score);
      observe(ib.obj_y[9:0]);
      observe(ib.obj_y[19:10]);

      // Nine exits saturate a 3-bit score
      expect_v("b_sat_score", 7);
      expect_v("b_sat_active", 2'b10);
      ticks(1, 1923);
      observe(ib.score);
      observe(ib.obj_active);

      // Tenth exit raises step to 2
      expect_v("b_lvl_active", 2'b01);
      expect_v("b_lvl_y0", 0);
      ticks(1, 1);
      observe(ib.obj_active);
      observe(ib.obj_y[9:0]);

      expect_v("b_step2_y0", 2);
      expect_v("b_step2_active", 2'b11);
      expect_v("b_step2_score", 7);
      ticks(1, 1);
      observe(ib.obj_y[9:0]);
      observe(ib.obj_active);
      observe(ib.score);

      // One level per exit: step climbs to its ceiling of 7
      start_pulse(2);
      expect_v("c_step7_y0", 14);
      expect_v("c_step7_score", 6);
      ticks(2, 255);
      observe(ic.obj_y[9:0]);
      observe(ic.score);

      expect_v("c_sixty_score", 60);
      expect_v("c_sixty_active", 0);
      ticks(2, 861);
      observe(ic.score);
      observe(ic.obj_active);

      ticks(2, 1);
      xc = fold(last_c);
      expect_v("c_spawn_x", xc);
      expect_v("c_ceiling_y0", 7);
      observe(ic.obj_x[9:0]);
      ticks(2, 1);
      observe(ic.obj_y[9:0]);

      // Collision with a same-cycle tick: no movement, game over, max score latched
      expect_v("c_hit_collision", 1);
      expect_v("c_hit_game_over", 1);
      expect_v("c_hit_playing", 0);
      expect_v("c_hit_y_frozen", 7);
      expect_v("c_hit_score", 60);
      expect_v("c_hit_max", 60);
      @(negedge clk);
      ic.player_x = xc + 10'd20;
      ic.player_y = 10'd27;
      ic.tick     = 1'b1;
      @(negedge clk);
      ic.tick = 1'b0;
      observe(ic.collision);
      observe(ic.game_over);
      observe(ic.playing);
      observe(ic.obj_y[9:0]);
      observe(ic.score);
      observe(ic.max_score);

      expect_v("c_pulse_end", 0);
      expect_v("c_over_held", 1);
      @(negedge clk);
      observe(ic.collision);
      observe(ic.game_over);

      // Ticks ignored in OVER
      expect_v("c_over_y", 7);
      expect_v("c_over_score", 60);
      ticks(2, 3);
      observe(ic.obj_y[9:0]);
      observe(ic.score);

      // Restart from OVER keeps max score
      ic.player_x = 10'd0;
      ic.player_y = 10'd600;
      expect_v("c_restart_playing", 1);
      expect_v("c_restart_game_over", 0);
      expect_v("c_restart_score", 0);
      expect_v("c_restart_active", 0);
      expect_v("c_restart_max", 60);
      expect_v("c_restart_y", 0);
      start_pulse(2);
      observe(ic.playing);
      observe(ic.game_over);
      observe(ic.score);
      observe(ic.obj_active);
      observe(ic.max_score);
      observe(ic.obj_y[9:0]);

      // Mid-game reset clears max score too
      expect_v("c_reset_max", 0);
      expect_v("c_reset_playing", 0);
      expect_v("a_reset_active", 0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      observe(ic.max_score);
      observe(ic.playing);
      observe(ia.obj_active);
      rst_n = 1'b1;

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
